// File: rtl/decim_average.sv
// Block-average decimator. Sums blocks of 2^k ce-qualified samples, rounds
// the block sum to its mean (round-half-up), and presents each mean on a
// ready/valid stream through a 2-entry output buffer. Results that arrive
// while the buffer is full and not draining are dropped, and a sticky
// overrun flag records the loss.
module decim_average #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LOG2   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic        [3:0]            decim_log2,
  output logic signed [DATA_WIDTH-1:0] m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         overrun
);

  localparam int ACC_W = DATA_WIDTH + MAX_LOG2;
  localparam int CNT_W = MAX_LOG2;
  localparam logic [3:0] K_MAX = 4'(MAX_LOG2);

  // Mean of a 2^k block: add half an LSB of the result, then arithmetic
  // shift. The sum is widened by one bit so the bias can never wrap. The
  // magnitude of a block mean never exceeds full scale, so the low
  // DATA_WIDTH bits are the exact result.
  function automatic logic signed [DATA_WIDTH-1:0] round_mean(
    input logic signed [ACC_W-1:0] s,
    input logic        [3:0]       k
  );
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] half;
    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;
    ext  = {s[ACC_W-1], s};
    half = '0;
    if (k != 4'd0) begin
      half = (ACC_W+1)'(1) << (k - 4'd1);
    end
    biased  = ext + half;
    shifted = biased >>> k;
    return shifted[DATA_WIDTH-1:0];
  endfunction

  // Accumulate stage state
  logic        [CNT_W-1:0] cnt_q;
  logic signed [ACC_W-1:0] acc_q;
  logic        [3:0]       k_act_q;
  logic signed [ACC_W-1:0] sum_q;
  logic                    done_q;

  // Output buffer state
  logic signed [DATA_WIDTH-1:0] mem_q [0:1];
  logic                         rd_q;
  logic                         wr_q;
  logic        [1:0]            count_q;
  logic                         overrun_q;

  // Combinational helpers
  logic        [3:0]            k_req;
  logic        [3:0]            k_blk;
  logic        [CNT_W-1:0]      last_cnt;
  logic                         is_last;
  logic signed [ACC_W-1:0]      din_ext;
  logic signed [ACC_W-1:0]      acc_sum;
  logic signed [DATA_WIDTH-1:0] mean;
  logic                         full;
  logic                         empty;
  logic                         pop;
  logic                         push_ok;
  logic                         drop;

  // ---- Accumulate stage: block counting and running sum on ce ----

  // Exponent in force for the current sample: a fresh block takes the
  // (clamped) requested exponent, a block in progress keeps its own.
  always_comb begin
    k_req    = (decim_log2 > K_MAX) ? K_MAX : decim_log2;
    k_blk    = (cnt_q == '0) ? k_req : k_act_q;
    last_cnt = ~({CNT_W{1'b1}} << k_blk);
    is_last  = (cnt_q == last_cnt);
    din_ext  = {{MAX_LOG2{din[DATA_WIDTH-1]}}, din};
    acc_sum  = acc_q + din_ext;
  end

  // Block counter, accumulator, latched exponent and the one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      k_act_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= ce && is_last;
      if (ce) begin
        if (cnt_q == '0) begin
          k_act_q <= k_req;
        end
        if (is_last) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= acc_sum;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Completed block sum, qualified downstream by done_q.
  always_ff @(posedge clk) begin
    if (ce && is_last) begin
      sum_q <= acc_sum;
    end
  end

  // ---- Rounding stage: mean of the completed block ----

  // k_act_q still holds the finished block's exponent in the done cycle:
  // the next block can only relatch it on the following edge.
  always_comb begin
    mean = round_mean(sum_q, k_act_q);
  end

  // ---- Output buffer: 2-entry FIFO with overrun detection ----

  // Push/pop decisions; a push into a full buffer is accepted only when the
  // head leaves in the same cycle.
  always_comb begin
    full    = (count_q == 2'd2);
    empty   = (count_q == 2'd0);
    pop     = !empty && m_tready;
    push_ok = done_q && (!full || pop);
    drop    = done_q && full && !pop;
  end

  // Buffer pointers, occupancy and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      count_q   <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_q <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Buffer storage; when full and popping, the slot written is the one
  // being vacated by the departing head.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= mean;
    end
  end

  // Registered head entry drives the stream; forced to zero while empty so
  // the port reads zero out of reset without resetting the storage.
  always_comb begin
    m_tvalid = !empty;
    m_tdata  = empty ? '0 : mem_q[rd_q];
    overrun  = overrun_q;
  end

endmodule

// File: tb/tb_decim_average.sv
// Scoreboard bench for decim_average: expected means are queued as stimulus
// is driven and compared as the DUT hands words over the stream.
module tb_decim_average;

  logic               clk;
  logic               rst;
  logic               ce;
  logic signed [15:0] din;
  logic        [3:0]  decim_log2;
  logic signed [15:0] m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic               overrun;

  int checks   = 0;
  int failures = 0;
  longint exp_q[$];

  decim_average #(.DATA_WIDTH(16), .MAX_LOG2(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .din        (din),
    .decim_log2 (decim_log2),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one strobed sample; returns 1 ns after the edge that samples it.
  task automatic drive_ce(input logic signed [15:0] v);
    ce  = 1'b1;
    din = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ce = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n  = 0;
    ce = 1'b0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, exp_q.size(), 0);
    idle(2);
  endtask

  // Scoreboard: every accepted word must match the oldest expectation.
  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", m_tdata, 99999);
      end else begin
        chk("word", m_tdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    ce         = 1'b1;
    din        = 16'sh7FFF;
    decim_log2 = 4'd2;
    m_tready   = 1'b1;

    // Reset held with strobes active
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", m_tvalid, 0);
      chk("rst_data", m_tdata, 0);
      chk("rst_overrun", overrun, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ce  = 1'b0;
    idle(2);

    // Rounding, k=2: 10/4 -> 3, -6/4 -> -1, with latency check
    exp_q.push_back(3);
    drive_ce(1);
    drive_ce(2);
    drive_ce(3);
    chk("lat_before", m_tvalid, 0);
    drive_ce(4);
    chk("lat_edge_e", m_tvalid, 0);
    exp_q.push_back(-1);
    drive_ce(-1);
    chk("lat_edge_e1", m_tvalid, 1);
    chk("lat_data", m_tdata, 3);
    drive_ce(-2);
    drive_ce(-2);
    drive_ce(-1);
    drain("drain_round");

    // Full scale, k=8
    decim_log2 = 4'd8;
    exp_q.push_back(32767);
    exp_q.push_back(-32768);
    for (int i = 0; i < 256; i++) drive_ce(16'sh7FFF);
    for (int i = 0; i < 256; i++) drive_ce(-16'sh8000);
    drain("drain_fullscale");

    // Exponent above MAX_LOG2 behaves as MAX_LOG2
    decim_log2 = 4'd12;
    exp_q.push_back(3);
    for (int i = 0; i < 256; i++) drive_ce(3);
    drain("drain_clamp");

    // Back-pressure, k=0
    decim_log2 = 4'd0;
    m_tready   = 1'b0;
    exp_q.push_back(10);
    exp_q.push_back(11);
    drive_ce(10);
    drive_ce(11);
    chk("bp_ovr_early", overrun, 0);
    drive_ce(12);
    chk("bp_ovr_full", overrun, 0);
    drive_ce(13);
    chk("bp_ovr_set", overrun, 1);
    idle(3);
    chk("bp_valid", m_tvalid, 1);
    chk("bp_head_stable", m_tdata, 10);
    m_tready = 1'b1;
    drain("drain_bp");
    chk("bp_ovr_sticky", overrun, 1);
    chk("bp_empty", m_tvalid, 0);

    // Sustained one result per clock at R=1
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(i * 3 - 7);
      drive_ce(16'(i * 3 - 7));
      if (i > 0) chk("r1_valid", m_tvalid, 1);
    end
    drain("drain_r1");

    // Exponent change mid-block: k=1 block, then k=3 block
    decim_log2 = 4'd1;
    exp_q.push_back(6);
    exp_q.push_back(5);
    drive_ce(5);
    decim_log2 = 4'd3;
    drive_ce(7);
    idle(1);
    chk("kchg_first_valid", m_tvalid, 1);
    for (int i = 1; i <= 8; i++) drive_ce(16'(i));
    drain("drain_kchg");

    // Mid-block reset, k=3
    for (int i = 0; i < 5; i++) drive_ce(100);
    rst = 1'b1;
    ce  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_overrun", overrun, 0);
    chk("mrst_valid", m_tvalid, 0);
    exp_q.push_back(4);
    for (int i = 0; i < 8; i++) drive_ce(4);
    drain("drain_mrst");
    chk("mrst_idle", m_tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
